// File: rtl/btb_assoc.sv
// btb_assoc: set-associative branch target buffer with true-LRU replacement.
//
// Fetch performs a combinational lookup on pc_in against the next-state arrays,
// so an update presented in the same cycle is visible to the lookup. Execute
// writes resolved branches back; taken branches allocate or refresh an entry.
//
// Optional feature macro: BTB_INVALIDATE_EN
//   defined   - a not-taken hit clears the valid bit of the matching way
//   undefined - a not-taken hit leaves the entry untouched
//
// Ports:
//   clock           in  1            sole clock, rising edge
//   reset           in  1            synchronous, active-high
//   enable          in  1            gates lookup and update
//   pc_in           in  32           fetch PC
//   if_branch       in  1            fetch instruction is a branch
//   ex_pc           in  32           PC of the resolved branch
//   calculated_pc   in  32           resolved target
//   ex_branch_taken in  1            resolved taken
//   ex_en_branch    in  1            resolution valid this cycle
//   target_pc       out 32           predicted next PC (pc_in on a miss)
//   valid_target    out 1            prediction hit
//   hit_way         out WB           way that hit (0 on a miss)
module btb_assoc #(
    parameter int unsigned NUM_SETS    = 16,
    parameter int unsigned NUM_WAYS    = 2,
    parameter int unsigned TAG_SIZE    = 10,
    parameter int unsigned TARGET_SIZE = 12,
    localparam int unsigned WB         = $clog2(NUM_WAYS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          enable,
    input  logic [31:0]   pc_in,
    input  logic          if_branch,
    input  logic [31:0]   ex_pc,
    input  logic [31:0]   calculated_pc,
    input  logic          ex_branch_taken,
    input  logic          ex_en_branch,
    output logic [31:0]   target_pc,
    output logic          valid_target,
    output logic [WB-1:0] hit_way
);

    localparam int unsigned IDX = $clog2(NUM_SETS);

    logic                   valid_q  [NUM_SETS][NUM_WAYS];
    logic                   valid_d  [NUM_SETS][NUM_WAYS];
    logic [TAG_SIZE-1:0]    tag_q    [NUM_SETS][NUM_WAYS];
    logic [TAG_SIZE-1:0]    tag_d    [NUM_SETS][NUM_WAYS];
    logic [TARGET_SIZE-1:0] target_q [NUM_SETS][NUM_WAYS];
    logic [TARGET_SIZE-1:0] target_d [NUM_SETS][NUM_WAYS];
    logic [WB-1:0]          age_q    [NUM_SETS][NUM_WAYS];
    logic [WB-1:0]          age_d    [NUM_SETS][NUM_WAYS];

    logic [IDX-1:0]         upd_idx;
    logic [TAG_SIZE-1:0]    upd_tag;
    logic [TARGET_SIZE-1:0] upd_target;
    logic                   upd_hit;
    logic [WB-1:0]          upd_hit_way;
    logic                   upd_free;
    logic [WB-1:0]          upd_free_way;
    logic [WB-1:0]          upd_lru_way;
    logic [WB-1:0]          upd_way;
    logic                   upd_write;

    logic [IDX-1:0]         fetch_idx;
    logic [TAG_SIZE-1:0]    fetch_tag;
    logic                   fetch_en;

    // Low alignment bits and high unused PC bits are intentionally ignored.
    logic                   unused_bits;
    assign unused_bits = ^{ex_pc, calculated_pc};

    assign upd_idx    = ex_pc[IDX+1:2];
    assign upd_tag    = ex_pc[TAG_SIZE+IDX+1:IDX+2];
    assign upd_target = calculated_pc[TARGET_SIZE+1:2];
    assign upd_write  = enable & ex_en_branch & ex_branch_taken;

    // Probe the update set: matching way, lowest invalid way, LRU way.
    always_comb begin
        upd_hit      = 1'b0;
        upd_hit_way  = '0;
        upd_free     = 1'b0;
        upd_free_way = '0;
        upd_lru_way  = '0;
        for (int k = 0; k < NUM_WAYS; k++) begin
            if (!upd_hit && valid_q[upd_idx][k] && tag_q[upd_idx][k] == upd_tag) begin
                upd_hit     = 1'b1;
                upd_hit_way = WB'(k);
            end
            if (!upd_free && !valid_q[upd_idx][k]) begin
                upd_free     = 1'b1;
                upd_free_way = WB'(k);
            end
            if (age_q[upd_idx][k] == WB'(NUM_WAYS - 1)) begin
                upd_lru_way = WB'(k);
            end
        end
        if (upd_hit) begin
            upd_way = upd_hit_way;
        end else if (upd_free) begin
            upd_way = upd_free_way;
        end else begin
            upd_way = upd_lru_way;
        end
    end

    // Next-state arrays; only set upd_idx can change in a cycle.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        age_d    = age_q;
        if (upd_write) begin
            valid_d[upd_idx][upd_way]  = 1'b1;
            tag_d[upd_idx][upd_way]    = upd_tag;
            target_d[upd_idx][upd_way] = upd_target;
            // Touch: ways younger than the touched one age by one.
            for (int k = 0; k < NUM_WAYS; k++) begin
                if (age_q[upd_idx][k] < age_q[upd_idx][upd_way]) begin
                    age_d[upd_idx][k] = age_q[upd_idx][k] + WB'(1);
                end
            end
            age_d[upd_idx][upd_way] = '0;
        end
`ifdef BTB_INVALIDATE_EN
        else if (enable && ex_en_branch && upd_hit) begin
            // Ages left alone: the freed way is reused as lowest invalid.
            valid_d[upd_idx][upd_hit_way] = 1'b0;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    valid_q[s][w]  <= 1'b0;
                    tag_q[s][w]    <= '0;
                    target_q[s][w] <= '0;
                    age_q[s][w]    <= WB'(w);
                end
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            age_q    <= age_d;
        end
    end

    assign fetch_idx = pc_in[IDX+1:2];
    assign fetch_tag = pc_in[TAG_SIZE+IDX+1:IDX+2];
    // Reset masks the forwarded update so outputs show miss values during reset.
    assign fetch_en  = enable & if_branch & ~reset;

    always_comb begin
        target_pc    = pc_in;
        valid_target = 1'b0;
        hit_way      = '0;
        if (fetch_en) begin
            for (int k = 0; k < NUM_WAYS; k++) begin
                if (!valid_target && valid_d[fetch_idx][k] &&
                    tag_d[fetch_idx][k] == fetch_tag) begin
                    valid_target                 = 1'b1;
                    hit_way                      = WB'(k);
                    target_pc[TARGET_SIZE+1:2]   = target_d[fetch_idx][k];
                end
            end
        end
    end

endmodule

// File: tb/tb_btb_assoc.sv
// tb_btb_assoc: directed, table-driven bench for btb_assoc (default parameters).
// Each vector is applied on the falling edge and checked 1 ns later, before the
// rising edge commits any update. Expectations depend on BTB_INVALIDATE_EN.
module tb_btb_assoc;

`ifdef BTB_INVALIDATE_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        enable;
    logic [31:0] pc_in;
    logic        if_branch;
    logic [31:0] ex_pc;
    logic [31:0] calculated_pc;
    logic        ex_branch_taken;
    logic        ex_en_branch;
    logic [31:0] target_pc;
    logic        valid_target;
    logic [0:0]  hit_way;

    btb_assoc dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .pc_in           (pc_in),
        .if_branch       (if_branch),
        .ex_pc           (ex_pc),
        .calculated_pc   (calculated_pc),
        .ex_branch_taken (ex_branch_taken),
        .ex_en_branch    (ex_en_branch),
        .target_pc       (target_pc),
        .valid_target    (valid_target),
        .hit_way         (hit_way)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic        en;
        logic        ifb;
        logic [31:0] pc;
        logic        ex_en;
        logic        tkn;
        logic [31:0] xpc;
        logic [31:0] calc;
        logic        exp_v;
        logic [31:0] exp_t;
        logic [0:0]  exp_w;
    } vec_t;

    vec_t vecs[$];
    int   applied;
    int   errors;

    task automatic add(input string name, input logic rst, input logic en, input logic ifb,
                       input logic [31:0] pc, input logic ex_en, input logic tkn,
                       input logic [31:0] xpc, input logic [31:0] calc,
                       input logic exp_v, input logic [31:0] exp_t, input logic [0:0] exp_w);
        vec_t v;
        v.name = name; v.rst = rst; v.en = en; v.ifb = ifb; v.pc = pc;
        v.ex_en = ex_en; v.tkn = tkn; v.xpc = xpc; v.calc = calc;
        v.exp_v = exp_v; v.exp_t = exp_t; v.exp_w = exp_w;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clock);
        reset = v.rst; enable = v.en; if_branch = v.ifb; pc_in = v.pc;
        ex_en_branch = v.ex_en; ex_branch_taken = v.tkn; ex_pc = v.xpc;
        calculated_pc = v.calc;
        #1;
        applied++;
        if (valid_target !== v.exp_v || target_pc !== v.exp_t || hit_way !== v.exp_w) begin
            errors++;
            $display("FAIL %s: got valid=%0b target=%h way=%0d, want valid=%0b target=%h way=%0d",
                     v.name, valid_target, target_pc, hit_way, v.exp_v, v.exp_t, v.exp_w);
        end
    endtask

    task automatic check_ages(input string name);
        for (int s = 0; s < 16; s++) begin
            for (int w = 0; w < 2; w++) begin
                applied++;
                if (dut.age_q[s][w] !== 1'(w)) begin
                    errors++;
                    $display("FAIL %s set %0d way %0d: got age=%0d, want %0d",
                             name, s, w, dut.age_q[s][w], w);
                end
            end
        end
    endtask

    initial begin
        applied = 0;
        errors  = 0;
        reset = 1'b1; enable = 1'b0; if_branch = 1'b0; pc_in = '0;
        ex_en_branch = 1'b0; ex_branch_taken = 1'b0; ex_pc = '0; calculated_pc = '0;

        // name            rst en ifb pc      exen tkn xpc     calc     v  target        way
        add("rst_lookup",   1, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   0, 32'h40,  0);
        add("post_rst",     0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   0, 32'h40,  0);
        add("fwd_alloc",    0, 1, 1, 32'h40,  1, 1, 32'h40,  32'h100, 1, 32'h100, 0);
        add("persist",      0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   1, 32'h100, 0);
        add("alloc_w1",     0, 1, 1, 32'h440, 1, 1, 32'h440, 32'h200, 1, 32'h200, 1);
        add("w0_still",     0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   1, 32'h100, 0);
        add("touch_w0",     0, 1, 1, 32'h440, 1, 1, 32'h40,  32'h100, 1, 32'h200, 1);
        add("evict_lru",    0, 1, 1, 32'h840, 1, 1, 32'h840, 32'h300, 1, 32'h300, 1);
        add("evicted_miss", 0, 1, 1, 32'h440, 0, 0, 32'h0,   32'h0,   0, 32'h440, 0);
        add("kept_w0",      0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   1, 32'h100, 0);
        add("new_w1",       0, 1, 1, 32'h840, 0, 0, 32'h0,   32'h0,   1, 32'h300, 1);
        add("en0_update",   0, 0, 1, 32'h80,  1, 1, 32'h80,  32'h180, 0, 32'h80,  0);
        add("en0_no_write", 0, 1, 1, 32'h80,  0, 0, 32'h0,   32'h0,   0, 32'h80,  0);
        add("ifb0_miss",    0, 1, 0, 32'h40,  0, 0, 32'h0,   32'h0,   0, 32'h40,  0);
        add("touch_w0_b",   0, 1, 1, 32'h40,  1, 1, 32'h40,  32'h100, 1, 32'h100, 0);
        add("nt_fwd",       0, 1, 1, 32'h40,  1, 0, 32'h40,  32'h100, !INV,
            INV ? 32'h40 : 32'h100, 0);
        add("nt_after",     0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   !INV,
            INV ? 32'h40 : 32'h100, 0);
        // Invalidated way 0 is reused; otherwise the LRU way 1 is evicted.
        add("realloc",      0, 1, 1, 32'hC40, 1, 1, 32'hC40, 32'h500, 1, 32'h500,
            INV ? 1'b0 : 1'b1);
        add("other_way",    0, 1, 1, 32'h840, 0, 0, 32'h0,   32'h0,   INV,
            INV ? 32'h300 : 32'h840, INV ? 1'b1 : 1'b0);
        add("rst_w_update", 1, 1, 1, 32'hC0,  1, 1, 32'hC0,  32'h1C0, 0, 32'hC0,  0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset with a concurrent update: update dropped, ages back to way index.
        @(posedge clock);
        #1;
        check_ages("age_after_rst");
        add("rst_drop_upd", 0, 1, 1, 32'hC0,  0, 0, 32'h0,   32'h0,   0, 32'hC0,  0);
        add("rst_cleared",  0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   0, 32'h40,  0);
        add("set1_alloc",   0, 1, 1, 32'h44,  1, 1, 32'h44,  32'h84,  1, 32'h84,  0);
        add("set0_isolate", 0, 1, 1, 32'h40,  0, 0, 32'h0,   32'h0,   0, 32'h40,  0);
        add("set1_persist", 0, 1, 1, 32'h44,  0, 0, 32'h0,   32'h0,   1, 32'h84,  0);
        for (int i = 20; i < vecs.size(); i++) run_vec(vecs[i]);

        @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
        $finish;
    end

endmodule
